cpu_control_unit: RTL and testbench

- Control FSM for the 4-bit CPU datapath.
- Accepts one 7-bit instruction per run handshake. Sequences the datapath's register-load enables, tristate bus enables, ALU latch enables and op_code. Signals completion with Done.
- Sits beside the datapath and drives every one of its control inputs. Guarantees at most one bus driver per cycle.

---
 rtl/cpu_ctrl_pkg.sv | 46 ++++
 rtl/cpu_control_unit_dec.sv | 13 +
 rtl/cpu_control_unit.sv | 143 ++++++++++++++
 tb/tb_cpu_control_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 4-bit CPU control unit: opcodes, FSM states,
// instruction field positions and the registered control word.
package cpu_ctrl_pkg;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_MOV     = 3'b001;
  localparam logic [2:0] OP_STORE   = 3'b010;
  localparam logic [2:0] OP_NOP     = 3'b011;
  localparam logic [2:0] OP_ALU_ADD = 3'b100;
  localparam logic [2:0] OP_ALU_SUB = 3'b101;
  localparam logic [2:0] OP_ALU_AND = 3'b110;
  localparam logic [2:0] OP_ALU_OR  = 3'b111;

  localparam int unsigned OP_MSB = 6;
  localparam int unsigned OP_LSB = 4;
  localparam int unsigned RX_MSB = 3;
  localparam int unsigned RX_LSB = 2;
  localparam int unsigned RY_MSB = 1;
  localparam int unsigned RY_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  typedef struct packed {
    logic       data_in;
    logic       ld_en;
    logic [1:0] ld_sel;
    logic       buf_en;
    logic [1:0] buf_sel;
    logic       store;
    logic       alu_in;
    logic       alu_out;
    logic       alu_open;
    logic       done;
  } ctrl_t;

  function automatic logic is_alu(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/cpu_control_unit_dec.sv
// Enable-gated 2-to-4 one-hot decoder used for the load and tristate groups.
module dec_2to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Control FSM for the 4-bit CPU datapath. Outputs are registered (Moore).
// Optional macro CU_BUS_CHECK_EN adds a sticky bus_err monitor output.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DONE_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [6:0] instr,
  output logic       busy,
  output logic [1:0] op_code,
  output logic       data_in,
  output logic       R0_out,
  output logic       R1_out,
  output logic       R2_out,
  output logic       R3_out,
  output logic       R0_buff,
  output logic       R1_buff,
  output logic       R2_buff,
  output logic       R3_buff,
  output logic       Store_out,
  output logic       ALU_in_Ext,
  output logic       ALU_out_Ext,
  output logic       alu_open,
`ifdef CU_BUS_CHECK_EN
  output logic       bus_err,
`endif
  output logic       Done
);

  state_t     state, state_nx, exit_state;
  logic [6:0] ir;
  ctrl_t      ctrl_nx, ctrl_q;
  logic [2:0] op;
  logic [1:0] rx, ry;
  logic [3:0] ld_vec, buf_vec;

  assign op = ir[OP_MSB:OP_LSB];
  assign rx = ir[RX_MSB:RX_LSB];
  assign ry = ir[RY_MSB:RY_LSB];
  assign exit_state = (DONE_HOLD != 0) ? S_FIN : S_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      ir     <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= state_nx;
      ctrl_q <= ctrl_nx;
      if (state == S_IDLE && run) ir <= instr;
    end
  end

  // The control word is decoded from the current state and registered, so
  // the enables for a phase appear in the cycle after that phase is entered.
  always_comb begin
    state_nx = state;
    ctrl_nx  = '0;
    case (state)
      S_IDLE: if (run) state_nx = S_T1;
      S_T1: begin
        if (is_alu(op)) begin
          ctrl_nx.buf_en  = 1'b1;
          ctrl_nx.buf_sel = rx;
          ctrl_nx.alu_in  = 1'b1;
          state_nx        = S_T2;
        end else begin
          ctrl_nx.done = 1'b1;
          state_nx     = exit_state;
          case (op)
            OP_LOAD: begin
              ctrl_nx.data_in = 1'b1;
              ctrl_nx.ld_en   = 1'b1;
              ctrl_nx.ld_sel  = rx;
            end
            OP_MOV: begin
              ctrl_nx.buf_en  = 1'b1;
              ctrl_nx.buf_sel = ry;
              ctrl_nx.ld_en   = 1'b1;
              ctrl_nx.ld_sel  = rx;
            end
            OP_STORE: begin
              ctrl_nx.buf_en  = 1'b1;
              ctrl_nx.buf_sel = rx;
              ctrl_nx.store   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_T2: begin
        ctrl_nx.buf_en  = 1'b1;
        ctrl_nx.buf_sel = ry;
        ctrl_nx.alu_out = 1'b1;
        state_nx        = S_T3;
      end
      S_T3: begin
        ctrl_nx.alu_open = 1'b1;
        ctrl_nx.ld_en    = 1'b1;
        ctrl_nx.ld_sel   = rx;
        ctrl_nx.done     = 1'b1;
        state_nx         = exit_state;
      end
      S_FIN: begin
        ctrl_nx.done = 1'b1;
        if (!run) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  dec_2to4 u_ld_dec  (.en(ctrl_q.ld_en),  .sel(ctrl_q.ld_sel),  .y(ld_vec));
  dec_2to4 u_buf_dec (.en(ctrl_q.buf_en), .sel(ctrl_q.buf_sel), .y(buf_vec));

  assign busy    = (state != S_IDLE);
  assign op_code = busy ? op[1:0] : 2'b00;

  assign data_in     = ctrl_q.data_in;
  assign {R3_out, R2_out, R1_out, R0_out}     = ld_vec;
  assign {R3_buff, R2_buff, R1_buff, R0_buff} = buf_vec;
  assign Store_out   = ctrl_q.store;
  assign ALU_in_Ext  = ctrl_q.alu_in;
  assign ALU_out_Ext = ctrl_q.alu_out;
  assign alu_open    = ctrl_q.alu_open;
  assign Done        = ctrl_q.done;

`ifdef CU_BUS_CHECK_EN
  int   n_drv;
  logic any_load;

  assign n_drv    = $countones({data_in, buf_vec, alu_open});
  assign any_load = (|ld_vec) | Store_out | ALU_in_Ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus_err <= 1'b0;
    else if (n_drv > 1 || (any_load && n_drv == 0)) bus_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: u0 (DONE_HOLD=0) with directed + random stimulus
// and a small datapath model, u1 (DONE_HOLD=1) with a random instruction stream.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run0 = 1'b0, run1 = 1'b0;
  logic [6:0] instr0 = '0, instr1 = '0;

  logic       busy0, din0, st0, ain0, aout0, aop0, done0;
  logic       busy1, din1, st1, ain1, aout1, aop1, done1;
  logic [1:0] opc0, opc1;
  logic [3:0] rout0, rbuf0, rout1, rbuf1;
`ifdef CU_BUS_CHECK_EN
  logic       berr0, berr1;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cpu_control_unit #(.DONE_HOLD(0)) u0 (
    .clk(clk), .reset(reset), .run(run0), .instr(instr0),
    .busy(busy0), .op_code(opc0), .data_in(din0),
    .R0_out(rout0[0]), .R1_out(rout0[1]), .R2_out(rout0[2]), .R3_out(rout0[3]),
    .R0_buff(rbuf0[0]), .R1_buff(rbuf0[1]), .R2_buff(rbuf0[2]), .R3_buff(rbuf0[3]),
    .Store_out(st0), .ALU_in_Ext(ain0), .ALU_out_Ext(aout0), .alu_open(aop0),
`ifdef CU_BUS_CHECK_EN
    .bus_err(berr0),
`endif
    .Done(done0)
  );

  cpu_control_unit #(.DONE_HOLD(1)) u1 (
    .clk(clk), .reset(reset), .run(run1), .instr(instr1),
    .busy(busy1), .op_code(opc1), .data_in(din1),
    .R0_out(rout1[0]), .R1_out(rout1[1]), .R2_out(rout1[2]), .R3_out(rout1[3]),
    .R0_buff(rbuf1[0]), .R1_buff(rbuf1[1]), .R2_buff(rbuf1[2]), .R3_buff(rbuf1[3]),
    .Store_out(st1), .ALU_in_Ext(ain1), .ALU_out_Ext(aout1), .alu_open(aop1),
`ifdef CU_BUS_CHECK_EN
    .bus_err(berr1),
`endif
    .Done(done1)
  );

  // Packed view: {busy, op_code, data_in, R3..R0_out, R3..R0_buff, Store, ALU_in, ALU_out, alu_open, Done}
  logic [16:0] pack0, pack1;
  assign pack0 = {busy0, opc0, din0, rout0, rbuf0, st0, ain0, aout0, aop0, done0};
  assign pack1 = {busy1, opc1, din1, rout1, rbuf1, st1, ain1, aout1, aop1, done1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] cword(input bit din, input int ld, input int bf,
                                        input bit st, input bit ain, input bit aout,
                                        input bit aop, input bit dn);
    logic [3:0] l, b;
    l = '0;
    b = '0;
    if (ld >= 0) l[ld] = 1'b1;
    if (bf >= 0) b[bf] = 1'b1;
    return {din, l, b, st, ain, aout, aop, dn};
  endfunction

  // Reference model: per instance, a schedule of control words for each accepted
  // instruction, plus the hold phase for the DONE_HOLD=1 instance.
  typedef enum {M_IDLE, M_RUN, M_HOLD} mphase_t;
  mphase_t     mph [2];
  logic [13:0] pw  [2][3];
  int          pn  [2];
  int          pi  [2];
  logic [6:0]  mir [2];
  logic [16:0] expv[2];

  // Datapath model driven by u0's enables.
  logic [3:0] dp_r [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] dp_q = '0, dp_g = '0, dp_leds = '0, data = '0;

  always @(negedge clk) begin
    logic [16:0] act [2];
    logic        rr;
    logic [6:0]  ri;
    logic [13:0] cw;
    logic        b;
    int          rx, ry, nd;
    logic [3:0]  bus;
    act[0] = pack0;
    act[1] = pack1;
    for (int k = 0; k < 2; k++) begin
      rr = (k == 0) ? run0 : run1;
      ri = (k == 0) ? instr0 : instr1;
      if (reset) begin
        mph[k] = M_IDLE; pn[k] = 0; pi[k] = 0; mir[k] = '0; expv[k] = '0;
      end
      chk((k == 0) ? "outputs_u0" : "outputs_u1", 32'(act[k]), 32'(expv[k]));
      if (!reset) begin
        cw = '0;
        case (mph[k])
          M_IDLE: if (rr) begin
            mir[k] = ri;
            rx = int'(ri[3:2]);
            ry = int'(ri[1:0]);
            pi[k] = 0;
            if (ri[6]) begin
              pw[k][0] = cword(0, -1, rx, 0, 1, 0, 0, 0);
              pw[k][1] = cword(0, -1, ry, 0, 0, 1, 0, 0);
              pw[k][2] = cword(0, rx, -1, 0, 0, 0, 1, 1);
              pn[k] = 3;
            end else begin
              pn[k] = 1;
              case (ri[5:4])
                2'd0:    pw[k][0] = cword(1, rx, -1, 0, 0, 0, 0, 1);
                2'd1:    pw[k][0] = cword(0, rx, ry, 0, 0, 0, 0, 1);
                2'd2:    pw[k][0] = cword(0, -1, rx, 1, 0, 0, 0, 1);
                default: pw[k][0] = cword(0, -1, -1, 0, 0, 0, 0, 1);
              endcase
            end
            mph[k] = M_RUN;
          end
          M_RUN: begin
            cw = pw[k][pi[k]];
            pi[k]++;
            if (pi[k] == pn[k]) mph[k] = (k == 1) ? M_HOLD : M_IDLE;
          end
          M_HOLD: begin
            cw = cword(0, -1, -1, 0, 0, 0, 0, 1);
            if (!rr) mph[k] = M_IDLE;
          end
        endcase
        b = (mph[k] != M_IDLE);
        expv[k] = {b, b ? mir[k][5:4] : 2'b00, cw};
      end
    end
`ifdef CU_BUS_CHECK_EN
    chk("bus_err_u0", 32'(berr0), 32'd0);
    chk("bus_err_u1", 32'(berr1), 32'd0);
`endif
    // Datapath effect of the enables visible now, applied at the coming edge.
    nd = int'(din0) + int'(aop0) + $countones(rbuf0);
    chk("bus_excl_u0", 32'((nd <= 1) && (!((|rout0) || st0 || ain0) || nd == 1)), 32'd1);
    bus = din0 ? data : aop0 ? dp_g : '0;
    for (int j = 0; j < 4; j++) if (rbuf0[j]) bus = dp_r[j];
    if (!reset) begin
      if (aout0) begin
        case (opc0)
          2'd0: dp_g = dp_q + bus;
          2'd1: dp_g = dp_q - bus;
          2'd2: dp_g = dp_q & bus;
          default: dp_g = dp_q | bus;
        endcase
      end
      if (ain0) dp_q = bus;
      if (st0) dp_leds = bus;
      for (int j = 0; j < 4; j++) if (rout0[j]) dp_r[j] = bus;
    end
  end

  task automatic issue0(input logic [6:0] ins, input int exp_lat, output logic [16:0] dw);
    int lat;
    @(posedge clk); #1;
    run0 = 1'b1;
    instr0 = ins;
    @(posedge clk); #1;
    run0 = 1'b0;
    instr0 = 7'($urandom);
    lat = 1;
    dw = '0;
    while (lat < 10) begin
      @(negedge clk);
      if (done0) begin
        dw = pack0;
        break;
      end
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic load0(input logic [1:0] rx, input logic [3:0] val);
    logic [16:0] dw;
    data = val;
    issue0({3'b000, rx, 2'b00}, 2, dw);
  endtask

  initial begin
    run1 = 1'b0;
    forever begin
      @(posedge clk); #1;
      run1 = ($urandom_range(0, 1) == 1);
      instr1 = 7'($urandom);
    end
  end

  initial begin
    logic [16:0] dw;
    logic [5:0]  bs;
    int          sc, dc;
    logic [3:0]  r1_before;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_outputs", 32'(pack0), 32'd0);

    data = 4'hA;
    issue0(7'b000_01_00, 2, dw);
    chk("load_done_word", 32'(dw), 32'(17'b0_00_1_0010_0000_00001));
    chk("load_r1", 32'(dp_r[1]), 32'hA);

    load0(2'd2, 4'h3);
    load0(2'd3, 4'h5);
    issue0(7'b100_10_11, 4, dw);
    chk("add_done_word", 32'(dw), 32'(17'b0_00_0_0100_0000_00011));
    chk("add_r2", 32'(dp_r[2]), 32'h8);

    load0(2'd0, 4'h7);
    issue0(7'b101_00_00, 4, dw);
    chk("sub_r0", 32'(dp_r[0]), 32'h0);

    load0(2'd1, 4'hC);
    load0(2'd2, 4'hA);
    issue0(7'b110_01_10, 4, dw);
    chk("and_r1", 32'(dp_r[1]), 32'h8);

    load0(2'd3, 4'hF);
    load0(2'd0, 4'h2);
    issue0(7'b100_11_00, 4, dw);
    chk("add_wrap_r3", 32'(dp_r[3]), 32'h1);

    // STORE R3 then NOP with run held high across the intervening IDLE cycle.
    bs = '0; sc = 0; dc = 0;
    @(posedge clk); #1;
    run0 = 1'b1;
    instr0 = 7'b010_11_00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) instr0 = 7'b011_00_00;
      if (i == 2) run0 = 1'b0;
      @(negedge clk);
      bs = {bs[4:0], busy0};
      sc = sc + int'(st0);
      dc = dc + int'(done0);
    end
    chk("store_nop_busy", 32'(bs), 32'(6'b101000));
    chk("store_pulses", 32'(sc), 32'd1);
    chk("store_nop_dones", 32'(dc), 32'd2);
    chk("leds", 32'(dp_leds), 32'h1);

    // Reset in T2 of an ALU op.
    load0(2'd1, 4'h5);
    r1_before = dp_r[1];
    @(posedge clk); #1;
    run0 = 1'b1;
    instr0 = 7'b100_01_10;
    @(posedge clk); #1;
    run0 = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("reset_async", 32'(pack0), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("r1_after_reset", 32'(dp_r[1]), 32'(r1_before));
    issue0(7'b100_01_10, 4, dw);
    chk("add_after_reset", 32'(dp_r[1]), 32'hF);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      run0 = ($urandom_range(0, 2) != 0);
      instr0 = 7'($urandom);
      data = 4'($urandom);
    end
    run0 = 1'b0;
    repeat (6) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
